imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader and write-side initiator for the MIPS instruction memory.
- Accepts a byte stream over a valid/ready handshake, validates a header and checksum, and assembles 32-bit instruction words MSB first (op field first).
- Issues one write per word into the writable instruction memory port.
- Holds the CPU in reset through cpu_hold until a load completes cleanly.

Parameters:
- WORDS_MAX, 9, instruction memory depth in words; largest legal word count.
- CNT_W, 4, width of word counters; must satisfy 2^CNT_W > WORDS_MAX.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- byte_valid  input  1  upstream byte present
- byte_data  input  8  upstream byte
- byte_ready  output  1  loader accepts byte this cycle
- wr_en  output  1  instruction memory write strobe, one cycle per word
- wr_addr  output  32  byte address of word (word_index*4, low 2 bits 0)
- wr_data  output  32  assembled instruction word
- cpu_hold  output  1  1 = keep CPU in reset
- done  output  1  load completed, checksum good
- error  output  1  load rejected (bad header or checksum)
- words_loaded  output  CNT_W  number of words written in current load

Behaviour:
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0. State goes to IDLE; the byte shift register, byte counter and checksum accumulator clear.
- Reset asserted mid-load aborts the load. Already-written memory words are not undone. State is as above.
- Transfer rule: a byte transfers on a rising edge with byte_valid=1 and byte_ready=1. byte_data is ignored otherwise. byte_valid may drop at any time; gaps only stall.
- Stream format:
  - header byte N, the word count;
  - then 4*N data bytes, MSB first per word;
  - then one checksum byte equal to the XOR of all 4*N data bytes (the header is excluded).
- IDLE: byte_ready=1. On a header byte:
  - N=0 or N>WORDS_MAX: go to ERR.
  - Otherwise: latch N, clear the word index, words_loaded and checksum, and go to DATA.
- DATA: byte_ready=1. Each accepted byte does three things:
  - shifts into the word register, wr_data <= {wr_data[23:0], byte};
  - XORs into the checksum;
  - increments the 2-bit byte counter.
  The 4th byte of a word moves the state to WRITE.
- WRITE: lasts exactly one cycle.
  - wr_en=1, wr_addr=word_index*4, wr_data holds the full word; byte_ready=0.
  - Next cycle: wr_en=0, words_loaded and word_index increment.
  - If words_loaded reaches N, go to CHECK; otherwise return to DATA.
  - Latency: the write is strobed in the cycle after the 4th byte transfers.
- CHECK: byte_ready=1. The accepted byte is compared with the accumulated checksum.
  - Equal: go to DONE.
  - Unequal: go to ERR.
- DONE: done=1 and cpu_hold=0 from the cycle after the checksum transfer. byte_ready=1. A new header byte restarts the load with the same rules as IDLE, and in that same cycle done clears and cpu_hold returns to 1.
- ERR: error=1, cpu_hold=1, done=0. byte_ready=1 and all bytes are discarded so upstream never hangs. ERR is sticky until reset.
- wr_addr width and arithmetic: word_index is zero-extended, then shifted left by 2. Maximum address = (WORDS_MAX-1)*4 (=32).
- cpu_hold is 1 in every state except DONE.
- wr_data keeps its last value outside WRITE.

Test Plan:
- Clean load:
  - Stimulus: bytes 02, 01 49 40 21, 01 49 40 22, 03 with byte_valid held high.
  - Required: wr_en pulses twice, with addr 0 / data 0x01494021, then addr 4 / data 0x01494022, each one cycle after its 4th byte.
  - Required: byte_ready=0 during each WRITE cycle; done=1 and cpu_hold=0 the cycle after 03; words_loaded=2.
- Checksum failure: same stream with checksum 0x00 -> two writes occur, then error=1, done=0, cpu_hold stays 1. Further bytes are accepted and ignored.
- Bad header:
  - Header 0x00 -> error=1 next cycle, no wr_en ever.
  - After reset, header 0x0A (10 > WORDS_MAX) -> same result.
- Backpressure/gaps:
  - Stimulus: clean-load stream with byte_valid toggling 1,0,1,0; byte_data driven to 0xFF whenever byte_valid=0.
  - Required: identical writes and done; 0xFF bytes never appear in wr_data or the checksum.
- Reset mid-load: reset after the 6th data byte of a 2-word load -> exactly one write (addr 0), all outputs return to their reset values, and a following full clean load completes normally.
- Reload from DONE:
  - After a clean load, send 01, 8C 03 00 04, 8C^03^00^04=0x8B.
  - Required: done drops and cpu_hold rises on the header; write at addr 0 data 0x8C030004; done=1 again, words_loaded=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for imem_loader.
// master = loader side, slave = upstream byte source / memory / CPU side.
interface imem_loader_if #(
    parameter int CNT_W = 4
);
    // A byte moves on a rising edge when byte_valid and byte_ready are both 1.
    // The source may drop byte_valid at any time, and byte_data matters only while byte_valid=1.
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             wr_en;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             cpu_hold;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, words_loaded
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: the stream is a header N, then 4*N bytes (MSB first), then an XOR checksum.
// Writes one word per 4 bytes and releases cpu_hold only after a clean load.
module imem_loader #(
    parameter int WORDS_MAX = 9,
    parameter int CNT_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    imem_loader_if.master       bus,
    output logic [2:0]          state_dbg
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DATA  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    localparam logic [7:0] MAX_BYTE = 8'(WORDS_MAX);

    logic [2:0]       state;
    logic [31:0]      word_r;
    logic [7:0]       csum;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] words_loaded;
    logic             ready;
    logic             xfer;
    logic             header_bad;

    // byte_ready is held low while reset is asserted and during the one-cycle WRITE slot.
    assign ready      = !reset && (state != WRITE);
    assign xfer       = bus.byte_valid && ready;
    assign header_bad = (bus.byte_data == 8'd0) || (bus.byte_data > MAX_BYTE);

    assign bus.byte_ready   = ready;
    assign bus.wr_en        = (state == WRITE);
    assign bus.wr_addr      = {{(30-CNT_W){1'b0}}, words_loaded, 2'b00};
    assign bus.wr_data      = word_r;
    assign bus.cpu_hold     = (state != DONE);
    assign bus.done         = (state == DONE);
    assign bus.error        = (state == ERR);
    assign bus.words_loaded = words_loaded;
    assign state_dbg        = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            word_r       <= 32'd0;
            csum         <= 8'd0;
            byte_cnt     <= 2'd0;
            word_count   <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (xfer) begin
                        if (header_bad) begin
                            state <= ERR;
                        end else begin
                            word_count   <= bus.byte_data[CNT_W-1:0];
                            words_loaded <= '0;
                            csum         <= 8'd0;
                            byte_cnt     <= 2'd0;
                            state        <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word_r   <= {word_r[23:0], bus.byte_data};
                        csum     <= csum ^ bus.byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) state <= WRITE;
                    end
                end
                WRITE: begin
                    // words_loaded doubles as the word index, so it must advance after the strobe.
                    words_loaded <= words_loaded + CNT_W'(1);
                    state <= (words_loaded + CNT_W'(1) == word_count) ? CHECK : DATA;
                end
                CHECK: begin
                    if (xfer) state <= (bus.byte_data == csum) ? DONE : ERR;
                end
                ERR: state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clean load, checksum/header errors, gaps, mid-load reset, reload.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] state_dbg;
    int         checks = 0;
    int         errors = 0;
    bit         gap = 1'b0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    imem_loader_if #(.CNT_W(4)) bus ();

    imem_loader #(.WORDS_MAX(9), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // write monitor feeding the scoreboard
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_writes(input string tag);
        logic [63:0] o, e;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_addr"}, o[63:32], e[63:32]);
            check({tag, "_data"}, o[31:0], e[31:0]);
        end
    endtask

    task automatic check_reset_values();
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_cpu_hold", bus.cpu_hold, 1);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_words_loaded", bus.words_loaded, 0);
    endtask

    task automatic apply_reset(input bit do_checks);
        @(negedge clk);
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'hFF;
        repeat (2) @(negedge clk);
        if (do_checks) check_reset_values();
        reset = 1'b0;
    endtask

    // driver: returns 1 ns after the rising edge that transferred the byte
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        if (gap) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            bus.byte_data = 8'hFF;
        end
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data = b;
        for (int n = 0; n < 20; n++) begin
            if (bus.byte_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'hFF;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed byte_ready=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] idx);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) send_byte(v[31-8*k -: 8]);
        check("write_strobe", bus.wr_en, 1);
        check("write_ready_low", bus.byte_ready, 0);
        check("write_addr", bus.wr_addr, idx * 4);
        check("write_data", bus.wr_data, w);
        exp_q.push_back({idx * 32'd4, w});
    endtask

    task automatic clean_load();
        send_byte(8'h02);
        check("hdr_hold", bus.cpu_hold, 1);
        send_word(32'h01494021, 0);
        send_word(32'h01494022, 1);
        send_byte(8'h03);
        check("load_done", bus.done, 1);
        check("load_cpu_hold", bus.cpu_hold, 0);
        check("load_error", bus.error, 0);
        check("load_words", bus.words_loaded, 2);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;

        // reset state
        apply_reset(1'b1);

        // clean load
        clear_sb();
        clean_load();
        check_writes("clean");

        // reload from DONE
        send_byte(8'h01);
        check("reload_done_drop", bus.done, 0);
        check("reload_hold_rise", bus.cpu_hold, 1);
        send_word(32'h8C030004, 0);
        send_byte(8'h8B);
        check("reload_done", bus.done, 1);
        check("reload_words", bus.words_loaded, 1);
        check_writes("reload");

        // checksum failure
        apply_reset(1'b0);
        clear_sb();
        send_byte(8'h02);
        send_word(32'h01494021, 0);
        send_word(32'h01494022, 1);
        send_byte(8'h00);
        check("csum_error", bus.error, 1);
        check("csum_done", bus.done, 0);
        check("csum_hold", bus.cpu_hold, 1);
        send_byte(8'h01);
        send_byte(8'h55);
        check("csum_sticky", bus.error, 1);
        check("csum_ready", bus.byte_ready, 1);
        check_writes("csum");

        // bad header zero
        apply_reset(1'b0);
        clear_sb();
        send_byte(8'h00);
        check("hdr0_error", bus.error, 1);
        send_byte(8'h01);
        repeat (4) send_byte(8'h12);
        check("hdr0_sticky", bus.error, 1);
        check_writes("hdr0");

        // bad header above depth
        apply_reset(1'b0);
        clear_sb();
        send_byte(8'h0A);
        check("hdr10_error", bus.error, 1);
        check("hdr10_hold", bus.cpu_hold, 1);
        check_writes("hdr10");

        // largest legal count is accepted
        apply_reset(1'b0);
        send_byte(8'h09);
        check("hdr9_error", bus.error, 0);
        check("hdr9_state", state_dbg, 1);

        // gaps with 0xFF on idle cycles
        apply_reset(1'b0);
        clear_sb();
        gap = 1'b1;
        clean_load();
        gap = 1'b0;
        check_writes("gap");

        // reset mid-load after the 6th data byte
        apply_reset(1'b0);
        clear_sb();
        send_byte(8'h02);
        send_word(32'h01494021, 0);
        send_byte(8'h01);
        send_byte(8'h49);
        apply_reset(1'b1);
        repeat (3) @(negedge clk);
        check_writes("midrst");
        clean_load();
        check_writes("midrst_reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
